interrupt_controller: RTL

- Requesting end of the CPU interrupt handshake: collects device interrupt lines, latches them as pending, and applies a mask and fixed priority.
- Presents one request at a time to coprocessor 0 on Interrupt/InteCause and holds it until CP0 returns InteAccept.
- Sits between the peripheral IRQ lines and the CP0 interrupt inputs.
- Software reads and writes its pending/mask registers over the same style of register port that CP0 uses.

---
 rtl/cp0_if_pkg.sv | 19 +
 rtl/irq_priority_enc.sv | 24 ++
 rtl/interrupt_controller.sv | 113 +++++++++++
 3 files changed

// File: rtl/cp0_if_pkg.sv
// Constants shared between the interrupt controller and CP0 software decoding:
// register map, request FSM encoding and cause/status field positions.
package cp0_if_pkg;

    localparam logic [1:0] PENDING_ADR = 2'd0;
    localparam logic [1:0] MASK_ADR    = 2'd1;
    localparam logic [1:0] STATUS_ADR  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_t;

    localparam int CAUSE_ID_LSB     = 0;
    localparam int STATUS_INT_BIT   = 0;
    localparam int STATUS_GRANT_LSB = 8;

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: index of the lowest set request bit, plus a valid flag.
module irq_priority_enc #(
    parameter int N = 8,
    parameter int W = 5
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Scanning downward lets the lowest set index be the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Collects device IRQ edges into Pending, applies Mask and fixed priority, and
// presents one request at a time to CP0 until it answers with InteAccept.
module interrupt_controller
    import cp0_if_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int ID_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] IrqIn,
    input  logic [1:0]       CtrlAdr,
    input  logic [31:0]      CtrlWdata,
    input  logic             CtrlWrite,
    output logic [31:0]      CtrlData,
    output logic             Interrupt,
    output logic [31:0]      InteCause,
    input  logic             InteAccept
);

    irq_state_t       state, state_next;
    logic [N_SRC-1:0] irq_prev, pending, mask;
    logic [N_SRC-1:0] irq_event, eligible, clr;
    logic [ID_W-1:0]  grant, enc_idx;
    logic             enc_valid, take_req, ack_clr, pend_write;
    logic [31:0]      status_word, rdata;
    logic             unused_wdata;

    assign irq_event    = IrqIn & ~irq_prev;
    assign eligible     = pending & mask;
    assign pend_write   = CtrlWrite && (CtrlAdr == PENDING_ADR);
    assign unused_wdata = ^CtrlWdata;

    irq_priority_enc #(.N(N_SRC), .W(ID_W)) u_enc (
        .req   (eligible),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        take_req   = 1'b0;
        ack_clr    = 1'b0;
        case (state)
            IDLE: if (enc_valid) begin
                take_req   = 1'b1;
                state_next = REQ;
            end
            REQ: if (InteAccept) begin
                ack_clr    = 1'b1;
                state_next = GAP;
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr[i] = (pend_write && CtrlWdata[i]) || (ack_clr && (grant == ID_W'(i)));
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_INT_BIT] = Interrupt;
        status_word[STATUS_GRANT_LSB +: ID_W] = grant;
    end

    always_comb begin
        rdata = '0;
        case (CtrlAdr)
            PENDING_ADR: rdata = 32'(pending);
            MASK_ADR:    rdata = 32'(mask);
            STATUS_ADR:  rdata = status_word;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev  <= '0;
            pending   <= '0;
            mask      <= '0;
            grant     <= '0;
            Interrupt <= 1'b0;
            InteCause <= '0;
            CtrlData  <= '0;
        end else begin
            irq_prev <= IrqIn;
            // A fresh edge always re-sets its bit, even when cleared this same cycle.
            pending  <= irq_event | (pending & ~clr);
            if (CtrlWrite && (CtrlAdr == MASK_ADR))
                mask <= CtrlWdata[N_SRC-1:0];
            if (take_req) begin
                grant     <= enc_idx;
                Interrupt <= 1'b1;
                InteCause <= 32'(enc_idx) << CAUSE_ID_LSB;
            end else if (ack_clr) begin
                Interrupt <= 1'b0;
            end
            CtrlData <= rdata;
        end
    end

endmodule
